// File: rtl/triplet_write_if.sv
// triplet_write_if: handshake, status and read-back bundle for the triplet_write buffer.
`default_nettype none

interface triplet_write_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 10
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] val1;
  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] val3;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] checksum;

  modport master (
    output clear, in_valid, val1, val2, val3, rd_addr,
    input  in_ready, done, count, rd_data, checksum
  );

  modport slave (
    input  clear, in_valid, val1, val2, val3, rd_addr,
    output in_ready, done, count, rd_data, checksum
  );
endinterface

`default_nettype wire

// File: rtl/triplet_write.sv
//------------------------------------------------------------------------------
// triplet_write: stores 3-word triplets sequentially into a DEPTH-word buffer,
// flags done when full, registered read-back. Optional TRIPLET_WRITE_CHECKSUM_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module triplet_write #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2700,
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 10
) (
  input  logic           clk,
  input  logic           rst,
  triplet_write_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR0  = 3'd1,
    WR1  = 3'd2,
    WR2  = 3'd3,
    FULL = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_hold0;
  logic [DATA_W-1:0] r_hold1;
  logic [DATA_W-1:0] r_hold2;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  // One extra bit so the full test stays exact even when DEPTH == 2**ADDR_W
  logic [ADDR_W:0]   w_idx_step;
  logic              w_rd_in_range;

  assign w_idx_step    = {1'b0, r_idx} + (ADDR_W+1)'(3);
  assign w_rd_in_range = ({1'b0, bus.rd_addr} < (ADDR_W+1)'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_addr    = r_idx;
    w_wr_data    = r_hold0;
    if (bus.clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            w_accept     = 1'b1;
            w_state_next = WR0;
          end
        end
        WR0: begin
          w_wr_en      = 1'b1;
          w_state_next = WR1;
        end
        WR1: begin
          w_wr_en      = 1'b1;
          w_wr_addr    = r_idx + ADDR_W'(1);
          w_wr_data    = r_hold1;
          w_state_next = WR2;
        end
        WR2: begin
          w_wr_en      = 1'b1;
          w_wr_addr    = r_idx + ADDR_W'(2);
          w_wr_data    = r_hold2;
          w_state_next = (w_idx_step == (ADDR_W+1)'(DEPTH)) ? FULL : IDLE;
        end
        FULL:    w_state_next = FULL;
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx     <= '0;
      r_count   <= '0;
      r_hold0   <= '0;
      r_hold1   <= '0;
      r_hold2   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_accept) begin
        r_hold0 <= bus.val1;
        r_hold1 <= bus.val2;
        r_hold2 <= bus.val3;
      end
      if (bus.clear) begin
        r_idx   <= '0;
        r_count <= '0;
      end else if (r_state == WR2) begin
        r_idx   <= w_idx_step[ADDR_W-1:0];
        r_count <= r_count + CNT_W'(1);
      end
      // Non-blocking read returns pre-write contents on a same-cycle collision
      r_rd_data <= w_rd_in_range ? r_mem[bus.rd_addr] : '0;
    end
  end

`ifdef TRIPLET_WRITE_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_checksum <= '0;
    else if (bus.clear) r_checksum <= '0;
    else if (w_wr_en) r_checksum <= r_checksum ^ w_wr_data;
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = '0;
`endif

  assign bus.in_ready = (r_state == IDLE);
  assign bus.done     = (r_state == FULL);
  assign bus.count    = r_count;
  assign bus.rd_data  = r_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_triplet_write.sv
// tb_triplet_write: vector table plus directed sequences for triplet_write.
`default_nettype none

module tb_triplet_write;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2700;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 10;

`ifdef TRIPLET_WRITE_CHECKSUM_EN
  localparam logic [31:0] EXP_CK = 32'hFFFFFF00;
`else
  localparam logic [31:0] EXP_CK = 32'h00000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  triplet_write_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  triplet_write #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        clr;
    logic        vld;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [31:0] v3;
    logic [11:0] addr;
    logic        e_rdy;
    logic        e_done;
    logic [9:0]  e_cnt;
    logic        chk_rd;
    logic [31:0] e_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (w >= 20) check("send_ready_timeout", {31'b0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b1;
    bus.val1 = a; bus.val2 = b; bus.val3 = c;
    tick();
    bus.in_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus.rd_addr = a;
    tick();
    d = bus.rd_data;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask

  function automatic logic [31:0] pat(input logic [31:0] base, input int w);
    return base + 32'(w);
  endfunction

  initial begin
    logic [31:0] d;
    int acc;
    int cyc;
    int stuck;

    vecs[0] = '{1'b0, 1'b1, 32'h11111111, 32'h22222222, 32'h33333333, 12'd0,    1'b0, 1'b0, 10'd0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0,                         12'd0,    1'b0, 1'b0, 10'd0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0,                         12'd0,    1'b0, 1'b0, 10'd0, 1'b1, 32'h11111111};
    vecs[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0,                         12'd1,    1'b1, 1'b0, 10'd1, 1'b1, 32'h22222222};
    vecs[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0,                         12'd2,    1'b1, 1'b0, 10'd1, 1'b1, 32'h33333333};
    vecs[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0,                         12'd2700, 1'b1, 1'b0, 10'd1, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0,                         12'd4095, 1'b1, 1'b0, 10'd1, 1'b1, 32'h0};
    vecs[7] = '{1'b1, 1'b1, 32'hBAD0BAD0, 32'hBAD1BAD1, 32'hBAD2BAD2,   12'd0,    1'b1, 1'b0, 10'd0, 1'b1, 32'h11111111};
    vecs[8] = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0,                         12'd1,    1'b1, 1'b0, 10'd0, 1'b1, 32'h22222222};

    bus.clear = 1'b0; bus.in_valid = 1'b0;
    bus.val1 = '0; bus.val2 = '0; bus.val3 = '0; bus.rd_addr = '0;

    #2 rst = 1'b1;
    #2;
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_done",     {31'b0, bus.done},     32'd0);
    check("rst_count",    {22'b0, bus.count},    32'd0);
    check("rst_rd_data",  bus.rd_data,           32'd0);
    check("rst_checksum", bus.checksum,          32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      bus.clear = vecs[i].clr; bus.in_valid = vecs[i].vld;
      bus.val1 = vecs[i].v1; bus.val2 = vecs[i].v2; bus.val3 = vecs[i].v3;
      bus.rd_addr = vecs[i].addr;
      tick();
      check($sformatf("vec%0d_in_ready", i), {31'b0, bus.in_ready}, {31'b0, vecs[i].e_rdy});
      check($sformatf("vec%0d_done", i),     {31'b0, bus.done},     {31'b0, vecs[i].e_done});
      check($sformatf("vec%0d_count", i),    {22'b0, bus.count},    {22'b0, vecs[i].e_cnt});
      if (vecs[i].chk_rd) check($sformatf("vec%0d_rd_data", i), bus.rd_data, vecs[i].e_rd);
    end
    bus.clear = 1'b0; bus.in_valid = 1'b0;

    // Checksum of a known triplet after a fresh clear
    pulse_clear();
    send(32'hF0F0F0F0, 32'h0F0F0F0F, 32'h000000FF);
    check("checksum_triplet", bus.checksum, EXP_CK);
    check("checksum_count",   {22'b0, bus.count}, 32'd1);

    // Clear during WR1 of the fifth triplet
    pulse_clear();
    for (int t = 0; t < 5; t++)
      send(pat(32'hAA000000, 3*t), pat(32'hAA000000, 3*t+1), pat(32'hAA000000, 3*t+2));
    check("prefill_count", {22'b0, bus.count}, 32'd5);
    pulse_clear();
    for (int t = 0; t < 4; t++)
      send(pat(32'hBB000000, 3*t), pat(32'hBB000000, 3*t+1), pat(32'hBB000000, 3*t+2));
    bus.in_valid = 1'b1;
    bus.val1 = pat(32'hBB000000, 12); bus.val2 = pat(32'hBB000000, 13); bus.val3 = pat(32'hBB000000, 14);
    tick();
    bus.in_valid = 1'b0;
    tick();
    pulse_clear();
    check("abort_count",    {22'b0, bus.count},    32'd0);
    check("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    send(32'hCC000000, 32'hCC000001, 32'hCC000002);
    rd(12'd0,  d); check("abort_next_addr0", d, 32'hCC000000);
    rd(12'd12, d); check("abort_mem12", d, pat(32'hBB000000, 12));
    rd(12'd13, d); check("abort_mem13", d, pat(32'hAA000000, 13));
    rd(12'd14, d); check("abort_mem14", d, pat(32'hAA000000, 14));
    check("abort_next_count", {22'b0, bus.count}, 32'd1);

    // Asynchronous reset in the middle of WR2
    bus.rd_addr = 12'd0;
    bus.in_valid = 1'b1;
    bus.val1 = 32'h12345678; bus.val2 = 32'h9ABCDEF0; bus.val3 = 32'h0F1E2D3C;
    tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    check("pre_rst_rd_data", bus.rd_data, 32'hCC000000);
    #2 rst = 1'b1;
    #1;
    check("async_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("async_rst_done",     {31'b0, bus.done},     32'd0);
    check("async_rst_count",    {22'b0, bus.count},    32'd0);
    check("async_rst_rd_data",  bus.rd_data,           32'd0);
    check("async_rst_checksum", bus.checksum,          32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Stream the full buffer with in_valid held high
    acc = 0;
    cyc = 0;
    bus.in_valid = 1'b1;
    while (bus.done !== 1'b1 && cyc < 5000) begin
      if (bus.in_ready === 1'b1) begin
        bus.val1 = pat(32'hA5000000, 3*acc);
        bus.val2 = pat(32'hA5000000, 3*acc+1);
        bus.val3 = pat(32'hA5000000, 3*acc+2);
        acc++;
      end
      tick();
      cyc++;
    end
    check("stream_done",     {31'b0, bus.done},     32'd1);
    check("stream_accepts",  32'(acc),              32'd900);
    check("stream_count",    {22'b0, bus.count},    32'd900);
    check("stream_in_ready", {31'b0, bus.in_ready}, 32'd0);
    bus.val1 = 32'hDEAD0001; bus.val2 = 32'hDEAD0002; bus.val3 = 32'hDEAD0003;
    stuck = 0;
    repeat (20) begin
      tick();
      if (bus.in_ready !== 1'b0 || bus.done !== 1'b1) stuck++;
    end
    check("full_holds", 32'(stuck), 32'd0);
    bus.in_valid = 1'b0;
    rd(12'd2699, d); check("full_mem2699", d, pat(32'hA5000000, 2699));
    rd(12'd0,    d); check("full_mem0",    d, 32'hA5000000);
    check("full_count", {22'b0, bus.count}, 32'd900);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
